// File: rtl/pipeline_stall_ctrl.sv
// Pipeline sequencing controller: hazard stalls, branch/jump redirects and
// multi-cycle data-memory handshake with timeout, plus a stall-cycle counter.
//   state    | meaning
//   RUN      | pipeline flowing; hazard/redirect logic active
//   MEM_WAIT | data-memory access in flight; whole pipeline frozen
module pipeline_stall_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic             isBranch,
  input  logic             isJump,
  input  logic             equal,
  input  logic [4:0]       exRt,
  input  logic [4:0]       exRd,
  input  logic             exMemRead,
  input  logic             exRegWrite,
  input  logic [4:0]       memRd,
  input  logic             memMemRead,
  input  logic             memReq,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             controlSel,
  output logic             ifFlush,
  output logic [1:0]       pcSrc,
  output logic             pipeHold,
  output logic             memStart,
  output logic             memTimeout,
  output logic [CNT_W-1:0] stallCycles
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t             state_q, state_d;
  logic               mem_served_q, mem_served_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

  logic start_access;
  logic freeze;
  logic load_use;
  logic br_ex_dep;
  logic br_mem_dep;
  logic hazard;

  always_comb begin
    start_access = (state_q == RUN) && memReq && !mem_served_q;
    freeze       = start_access || (state_q == MEM_WAIT);

    load_use   = exMemRead && (exRt != 5'd0) && ((exRt == idRs) || (exRt == idRt));
    br_ex_dep  = exRegWrite && (exRd != 5'd0) && ((exRd == idRs) || (exRd == idRt));
    br_mem_dep = memMemRead && (memRd != 5'd0) && ((memRd == idRs) || (memRd == idRt));
    hazard     = load_use || (isBranch && (br_ex_dep || br_mem_dep));
  end

  // Output priority: rst > freeze > hazard > jump > branch > normal.
  always_comb begin
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    controlSel = 1'b1;
    ifFlush    = 1'b0;
    pcSrc      = 2'd0;
    pipeHold   = 1'b0;
    memStart   = 1'b0;
    if (!rst) begin
      if (freeze) begin
        pipeHold  = 1'b1;
        pcWrite   = 1'b0;
        ifidWrite = 1'b0;
        memStart  = start_access;
      end else if (hazard) begin
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        controlSel = 1'b0;
      end else if (isJump) begin
        pcSrc   = 2'd2;
        ifFlush = 1'b1;
      end else if (isBranch && equal) begin
        pcSrc   = 2'd1;
        ifFlush = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    mem_served_d   = mem_served_q;
    wait_cnt_d     = wait_cnt_q;
    mem_timeout_d  = mem_timeout_q;
    stall_cycles_d = stall_cycles_q;

    case (state_q)
      RUN: begin
        if (start_access) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end else begin
          mem_served_d = 1'b0;
        end
      end
      MEM_WAIT: begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        if (memReady) begin
          state_d      = RUN;
          mem_served_d = 1'b1;
        end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d       = RUN;
          mem_served_d  = 1'b1;
          mem_timeout_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (!pcWrite && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      mem_served_q   <= 1'b0;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      mem_served_q   <= mem_served_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign memTimeout  = mem_timeout_q;
  assign stallCycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with MEM_TIMEOUT=4, CNT_W=8.
// Output bundle order: {pcWrite, ifidWrite, controlSel, ifFlush, pcSrc[1:0], pipeHold, memStart}.
module tb_pipeline_stall_ctrl;

  localparam int CW = 8;

  localparam logic [7:0] O_NORM  = 8'b1110_0000;
  localparam logic [7:0] O_HAZ   = 8'b0000_0000;
  localparam logic [7:0] O_HOLD  = 8'b0010_0010;
  localparam logic [7:0] O_START = 8'b0010_0011;
  localparam logic [7:0] O_BR    = 8'b1111_0100;
  localparam logic [7:0] O_JMP   = 8'b1111_1000;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] idRs, idRt, exRt, exRd, memRd;
  logic isBranch, isJump, equal, exMemRead, exRegWrite, memMemRead, memReq, memReady;
  logic pcWrite, ifidWrite, controlSel, ifFlush, pipeHold, memStart, memTimeout;
  logic [1:0] pcSrc;
  logic [CW-1:0] stallCycles;
  logic [7:0] outs;

  int checks = 0;
  int failures = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  assign outs = {pcWrite, ifidWrite, controlSel, ifFlush, pcSrc, pipeHold, memStart};

  pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .isBranch(isBranch), .isJump(isJump),
    .equal(equal), .exRt(exRt), .exRd(exRd), .exMemRead(exMemRead), .exRegWrite(exRegWrite),
    .memRd(memRd), .memMemRead(memMemRead), .memReq(memReq), .memReady(memReady),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .controlSel(controlSel), .ifFlush(ifFlush),
    .pcSrc(pcSrc), .pipeHold(pipeHold), .memStart(memStart), .memTimeout(memTimeout),
    .stallCycles(stallCycles)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    idRs = 0; idRt = 0; exRt = 0; exRd = 0; memRd = 0;
    isBranch = 0; isJump = 0; equal = 0; exMemRead = 0; exRegWrite = 0;
    memMemRead = 0; memReq = 0; memReady = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    tick(); tick();
    rst = 0; #2;
    checks++; if (outs !== O_NORM) begin failures++; $display("FAIL reset_outs got=%b exp=%b", outs, O_NORM); end
    checks++; if (stallCycles !== 8'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stallCycles); end
    checks++; if (memTimeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", memTimeout); end
    tick();
  endtask

  task automatic test_load_use();
    exMemRead = 1; exRt = 5; idRs = 5; #2;
    checks++; if (outs !== O_HAZ) begin failures++; $display("FAIL lu_rs got=%b exp=%b", outs, O_HAZ); end
    tick(); exp_stall++;
    checks++; if (stallCycles !== CW'(exp_stall)) begin failures++; $display("FAIL lu_cnt got=%0d exp=%0d", stallCycles, exp_stall); end
    idRs = 7; idRt = 5; #2;
    checks++; if (outs !== O_HAZ) begin failures++; $display("FAIL lu_rt got=%b exp=%b", outs, O_HAZ); end
    tick(); exp_stall++;
    idRt = 9; #2;
    checks++; if (outs !== O_NORM) begin failures++; $display("FAIL lu_nomatch got=%b exp=%b", outs, O_NORM); end
    exRt = 0; idRs = 0; idRt = 0; #2;
    checks++; if (outs !== O_NORM) begin failures++; $display("FAIL lu_r0 got=%b exp=%b", outs, O_NORM); end
    clear_inputs(); tick();
    checks++; if (stallCycles !== CW'(exp_stall)) begin failures++; $display("FAIL lu_cnt2 got=%0d exp=%0d", stallCycles, exp_stall); end
  endtask

  task automatic test_redirect();
    isBranch = 1; equal = 1; #2;
    checks++; if (outs !== O_BR) begin failures++; $display("FAIL br_taken got=%b exp=%b", outs, O_BR); end
    isJump = 1; #2;
    checks++; if (outs !== O_JMP) begin failures++; $display("FAIL br_jump_prio got=%b exp=%b", outs, O_JMP); end
    isBranch = 0; equal = 0; #2;
    checks++; if (outs !== O_JMP) begin failures++; $display("FAIL jump got=%b exp=%b", outs, O_JMP); end
    isJump = 0; isBranch = 1; #2;
    checks++; if (outs !== O_NORM) begin failures++; $display("FAIL br_not_taken got=%b exp=%b", outs, O_NORM); end
    clear_inputs(); tick();
  endtask

  task automatic test_branch_hazard();
    isBranch = 1; equal = 1; exRegWrite = 1; exRd = 3; idRt = 3; #2;
    checks++; if (outs !== O_HAZ) begin failures++; $display("FAIL brh_ex got=%b exp=%b", outs, O_HAZ); end
    tick(); exp_stall++;
    exRd = 0; #2;
    checks++; if (outs !== O_BR) begin failures++; $display("FAIL brh_r0 got=%b exp=%b", outs, O_BR); end
    exRegWrite = 0; memMemRead = 1; memRd = 3; idRs = 3; idRt = 0; #2;
    checks++; if (outs !== O_HAZ) begin failures++; $display("FAIL brh_mem got=%b exp=%b", outs, O_HAZ); end
    tick(); exp_stall++;
    isBranch = 0; #2;
    checks++; if (outs !== O_NORM) begin failures++; $display("FAIL brh_nobranch got=%b exp=%b", outs, O_NORM); end
    clear_inputs(); tick();
    checks++; if (stallCycles !== CW'(exp_stall)) begin failures++; $display("FAIL brh_cnt got=%0d exp=%0d", stallCycles, exp_stall); end
  endtask

  task automatic test_mem_wait();
    memReq = 1; #2;
    checks++; if (outs !== O_START) begin failures++; $display("FAIL mw_start got=%b exp=%b", outs, O_START); end
    tick(); exp_stall++;
    checks++; if (outs !== O_HOLD) begin failures++; $display("FAIL mw_wait1 got=%b exp=%b", outs, O_HOLD); end
    tick(); exp_stall++;
    exMemRead = 1; exRt = 4; idRs = 4; isJump = 1; #2;
    checks++; if (outs !== O_HOLD) begin failures++; $display("FAIL mw_override got=%b exp=%b", outs, O_HOLD); end
    tick(); exp_stall++;
    exMemRead = 0; exRt = 0; idRs = 0; isJump = 0; memReady = 1; #2;
    checks++; if (outs !== O_HOLD) begin failures++; $display("FAIL mw_ready got=%b exp=%b", outs, O_HOLD); end
    tick(); exp_stall++;
    memReady = 0; #2;
    checks++; if (outs !== O_NORM) begin failures++; $display("FAIL mw_resume got=%b exp=%b", outs, O_NORM); end
    checks++; if (stallCycles !== CW'(exp_stall)) begin failures++; $display("FAIL mw_cnt got=%0d exp=%0d", stallCycles, exp_stall); end
    checks++; if (memTimeout !== 1'b0) begin failures++; $display("FAIL mw_no_timeout got=%b exp=0", memTimeout); end
    tick();
    checks++; if (outs !== O_START) begin failures++; $display("FAIL mw_next got=%b exp=%b", outs, O_START); end
    memReq = 0; #2;
    tick();
  endtask

  task automatic test_timeout();
    memReq = 1; #2;
    checks++; if (outs !== O_START) begin failures++; $display("FAIL to_start got=%b exp=%b", outs, O_START); end
    tick(); tick(); tick(); tick(); exp_stall += 4;
    checks++; if (outs !== O_HOLD) begin failures++; $display("FAIL to_last_wait got=%b exp=%b", outs, O_HOLD); end
    checks++; if (memTimeout !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0", memTimeout); end
    tick(); exp_stall++;
    checks++; if (memTimeout !== 1'b1) begin failures++; $display("FAIL to_set got=%b exp=1", memTimeout); end
    checks++; if (outs !== O_NORM) begin failures++; $display("FAIL to_run got=%b exp=%b", outs, O_NORM); end
    checks++; if (stallCycles !== CW'(exp_stall)) begin failures++; $display("FAIL to_cnt got=%0d exp=%0d", stallCycles, exp_stall); end
    memReq = 0; tick(); tick();
    checks++; if (memTimeout !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", memTimeout); end
  endtask

  task automatic test_reset_mid_wait();
    memReq = 1; #2;
    checks++; if (outs !== O_START) begin failures++; $display("FAIL rw_start got=%b exp=%b", outs, O_START); end
    tick();
    checks++; if (outs !== O_HOLD) begin failures++; $display("FAIL rw_wait got=%b exp=%b", outs, O_HOLD); end
    rst = 1; #2;
    checks++; if (outs !== O_NORM) begin failures++; $display("FAIL rw_rst_outs got=%b exp=%b", outs, O_NORM); end
    tick();
    rst = 0; memReq = 0; #2; exp_stall = 0;
    checks++; if (outs !== O_NORM) begin failures++; $display("FAIL rw_after got=%b exp=%b", outs, O_NORM); end
    checks++; if (stallCycles !== 8'd0) begin failures++; $display("FAIL rw_cnt got=%0d exp=0", stallCycles); end
    checks++; if (memTimeout !== 1'b0) begin failures++; $display("FAIL rw_timeout got=%b exp=0", memTimeout); end
    tick();
    memReq = 1; #2;
    checks++; if (outs !== O_START) begin failures++; $display("FAIL rw_fresh got=%b exp=%b", outs, O_START); end
    tick(); exp_stall++;
    memReady = 1; #2;
    tick(); exp_stall++;
    memReq = 0; memReady = 0; #2;
    checks++; if (outs !== O_NORM) begin failures++; $display("FAIL rw_done got=%b exp=%b", outs, O_NORM); end
    checks++; if (stallCycles !== CW'(exp_stall)) begin failures++; $display("FAIL rw_cnt2 got=%0d exp=%0d", stallCycles, exp_stall); end
    tick();
  endtask

  task automatic test_saturation();
    exMemRead = 1; exRt = 1; idRs = 1;
    repeat (260) tick();
    checks++; if (stallCycles !== 8'hFF) begin failures++; $display("FAIL sat_cnt got=%0d exp=255", stallCycles); end
    clear_inputs(); tick();
    checks++; if (stallCycles !== 8'hFF) begin failures++; $display("FAIL sat_hold got=%0d exp=255", stallCycles); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_branch_hazard();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
